// File: rtl/dma_clk_gate_ctrl.sv
// Per-channel clock-enable sequencer: wakes a channel's gated clock on request,
// acknowledges once the clock has settled, and gates it off after an idle window.
module dma_clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 16,
    parameter int CNT_W    = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic [NUM_CH-1:0] i_busy,
    input  logic              i_force_on,
    output logic [NUM_CH-1:0] o_gate_en,
    output logic [NUM_CH-1:0] o_ack,
    output logic              o_all_idle
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_ON,
        ST_COOL
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

    state_t            r_state [NUM_CH];
    logic [CNT_W-1:0]  r_cnt   [NUM_CH];

    state_t            w_state_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] w_en_nxt;
    logic [NUM_CH-1:0] w_ack_nxt;
    logic [NUM_CH-1:0] w_off_nxt;

    // Counters restart on every state entry, so they only ever count up to a terminal value.
    always_comb begin
        w_en_nxt  = '0;
        w_ack_nxt = '0;
        w_off_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_OFF: begin
                    if (i_req[i]) begin
                        w_state_nxt[i] = ST_WAKE;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_WAKE: begin
                    if (r_cnt[i] == WAKE_LAST) begin
                        w_state_nxt[i] = ST_ON;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                ST_ON: begin
                    if (!i_req[i] && !i_busy[i]) begin
                        w_state_nxt[i] = ST_COOL;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_COOL: begin
                    if (i_req[i] || i_busy[i]) begin
                        w_state_nxt[i] = ST_ON;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == IDLE_LAST) begin
                        w_state_nxt[i] = ST_OFF;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_OFF;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
            w_off_nxt[i] = (w_state_nxt[i] == ST_OFF);
            w_en_nxt[i]  = !w_off_nxt[i] || i_force_on;
            w_ack_nxt[i] = (w_state_nxt[i] == ST_ON) || (w_state_nxt[i] == ST_COOL);
        end
    end

    // Outputs are registered from next-state so they line up with the state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_OFF;
                r_cnt[i]   <= '0;
            end
            o_gate_en  <= '0;
            o_ack      <= '0;
            o_all_idle <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            o_gate_en  <= w_en_nxt;
            o_ack      <= w_ack_nxt;
            o_all_idle <= &w_off_nxt;
        end
    end

endmodule

// File: tb/tb_dma_clk_gate_ctrl.sv
// Self-checking bench for dma_clk_gate_ctrl: vector table, directed corner
// sequences and randomized traffic against a timestamp-based reference model.
module tb_dma_clk_gate_ctrl;

    localparam int NUM_CH   = 4;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 16;
    localparam int CNT_W    = 5;

    logic              clk = 1'b0;
    logic              rstN;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] busy;
    logic              forceOn;
    logic [NUM_CH-1:0] gateEn;
    logic [NUM_CH-1:0] ack;
    logic              allIdle;

    always #5 clk = ~clk;

    dma_clk_gate_ctrl #(
        .NUM_CH  (NUM_CH),
        .WAKE_CYC(WAKE_CYC),
        .IDLE_CYC(IDLE_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_req     (req),
        .i_busy    (busy),
        .i_force_on(forceOn),
        .o_gate_en (gateEn),
        .o_ack     (ack),
        .o_all_idle(allIdle)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model: a channel is either powered or not; when powered it
    // remembers the edge at which ack becomes valid and the edge idling began.
    bit                mOn        [NUM_CH];
    int                mAckAt     [NUM_CH];
    int                mIdleSince [NUM_CH];
    logic [NUM_CH-1:0] mGate;
    logic [NUM_CH-1:0] mAck;
    logic              mIdle;

    typedef struct {
        logic [NUM_CH-1:0] req;
        logic [NUM_CH-1:0] busy;
        logic              forceOn;
        logic [NUM_CH-1:0] expGate;
        logic [NUM_CH-1:0] expAck;
        logic              expIdle;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic expectOut(input string name, input logic [NUM_CH-1:0] g,
                             input logic [NUM_CH-1:0] a, input logic idle);
        checkOutput({name, "_gate"}, 32'(gateEn), 32'(g));
        checkOutput({name, "_ack"},  32'(ack),    32'(a));
        checkOutput({name, "_idle"}, 32'(allIdle), 32'(idle));
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            mOn[i]        = 1'b0;
            mAckAt[i]     = 0;
            mIdleSince[i] = -1;
        end
        mGate = '0;
        mAck  = '0;
        mIdle = 1'b1;
    endtask

    task automatic modelEdge();
        cycle++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!mOn[i]) begin
                if (req[i]) begin
                    mOn[i]        = 1'b1;
                    mAckAt[i]     = cycle + WAKE_CYC;
                    mIdleSince[i] = -1;
                end
            end else if (cycle > mAckAt[i]) begin
                if (req[i] || busy[i]) begin
                    mIdleSince[i] = -1;
                end else if (mIdleSince[i] < 0) begin
                    mIdleSince[i] = cycle;
                end else if (cycle - mIdleSince[i] == IDLE_CYC) begin
                    mOn[i]        = 1'b0;
                    mIdleSince[i] = -1;
                end
            end
        end
        mIdle = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            mGate[i] = mOn[i] || forceOn;
            mAck[i]  = mOn[i] && (cycle >= mAckAt[i]);
            if (mOn[i]) mIdle = 1'b0;
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_gate", 32'(gateEn),  32'(mGate));
        checkOutput("model_ack",  32'(ack),     32'(mAck));
        checkOutput("model_idle", 32'(allIdle), 32'(mIdle));
    endtask

    initial begin
        req     = '0;
        busy    = '0;
        forceOn = 1'b0;
        rstN    = 1'b1;
        modelReset();
        #2 rstN = 1'b0;
        #1;
        expectOut("init_reset", 4'h0, 4'h0, 1'b1);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Vector table: force_on with a wake on channel 1, then busy and cool entry.
        vecs[0] = '{4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 1'b1};
        vecs[1] = '{4'h2, 4'h0, 1'b1, 4'hF, 4'h0, 1'b0};
        vecs[2] = '{4'h2, 4'h0, 1'b1, 4'hF, 4'h0, 1'b0};
        vecs[3] = '{4'h2, 4'h0, 1'b1, 4'hF, 4'h2, 1'b0};
        vecs[4] = '{4'h2, 4'h0, 1'b0, 4'h2, 4'h2, 1'b0};
        vecs[5] = '{4'h0, 4'h2, 1'b0, 4'h2, 4'h2, 1'b0};
        vecs[6] = '{4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 1'b0};
        vecs[7] = '{4'h0, 4'h1, 1'b0, 4'h2, 4'h2, 1'b0};
        for (int v = 0; v < 8; v++) begin
            req     = vecs[v].req;
            busy    = vecs[v].busy;
            forceOn = vecs[v].forceOn;
            applyStimulus();
            expectOut($sformatf("vec%0d", v), vecs[v].expGate, vecs[v].expAck, vecs[v].expIdle);
        end
        req  = '0;
        busy = '0;

        // Async reset with channel 0 in ON drops everything without waiting for a clock.
        req[0] = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("pre_reset_ack0", 32'(ack[0]), 32'd1);
        #2 rstN = 1'b0;
        #1;
        expectOut("async_reset", 4'h0, 4'h0, 1'b1);
        modelReset();
        req = '0;
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (3) begin
            applyStimulus();
            expectOut("post_reset_hold", 4'h0, 4'h0, 1'b1);
        end

        // Wake with default delay, then a full cool-down on channel 0.
        req[0] = 1'b1;
        applyStimulus();
        expectOut("wake_e0", 4'h1, 4'h0, 1'b0);
        applyStimulus();
        expectOut("wake_e1", 4'h1, 4'h0, 1'b0);
        applyStimulus();
        expectOut("wake_e2", 4'h1, 4'h1, 1'b0);
        repeat (4) applyStimulus();
        req[0] = 1'b0;
        applyStimulus();
        expectOut("cool_entry", 4'h1, 4'h1, 1'b0);
        for (int k = 1; k < IDLE_CYC; k++) begin
            applyStimulus();
            expectOut("cool_hold", 4'h1, 4'h1, 1'b0);
        end
        applyStimulus();
        expectOut("cool_off", 4'h0, 4'h0, 1'b1);

        // Cool abort on channel 1 at cnt 9 restarts the idle window.
        req[1] = 1'b1;
        repeat (3) applyStimulus();
        req[1] = 1'b0;
        applyStimulus();
        repeat (9) applyStimulus();
        busy[1] = 1'b1;
        applyStimulus();
        expectOut("abort_on", 4'h2, 4'h2, 1'b0);
        busy[1] = 1'b0;
        applyStimulus();
        for (int k = 1; k < IDLE_CYC; k++) begin
            applyStimulus();
            expectOut("abort_hold", 4'h2, 4'h2, 1'b0);
        end
        applyStimulus();
        expectOut("abort_off", 4'h0, 4'h0, 1'b1);

        // A single-cycle request still completes the wake, then cools off.
        req[2] = 1'b1;
        applyStimulus();
        expectOut("pulse_wake", 4'h4, 4'h0, 1'b0);
        req[2] = 1'b0;
        applyStimulus();
        expectOut("pulse_wake2", 4'h4, 4'h0, 1'b0);
        applyStimulus();
        expectOut("pulse_on", 4'h4, 4'h4, 1'b0);
        applyStimulus();
        for (int k = 1; k < IDLE_CYC; k++) applyStimulus();
        expectOut("pulse_hold", 4'h4, 4'h4, 1'b0);
        applyStimulus();
        expectOut("pulse_off", 4'h0, 4'h0, 1'b1);

        // Simultaneous requests on channels 0 and 3 proceed independently.
        req = 4'h9;
        applyStimulus();
        expectOut("dual_wake", 4'h9, 4'h0, 1'b0);
        applyStimulus();
        applyStimulus();
        expectOut("dual_ack", 4'h9, 4'h9, 1'b0);
        req = '0;
        repeat (IDLE_CYC + 2) applyStimulus();
        expectOut("dual_off", 4'h0, 4'h0, 1'b1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(11) == 0) req[i] = ~req[i];
                busy[i] = ($urandom_range(9) == 0);
            end
            if ($urandom_range(39) == 0) forceOn = ~forceOn;
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
